// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types and constants for the program-counter sequencer.
//   seq_state_t : sequencer FSM states (BOOT, RUN, HALT)
//   seq_act_t   : one-hot-free encoding of the action chosen for a RUN cycle
//   INSTR_BYTES_DEF : default sequential PC increment in bytes
package pc_seq_pkg;

    localparam int INSTR_BYTES_DEF = 4;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } seq_state_t;

    typedef enum logic [2:0] {
        ACT_HALT    = 3'd0,
        ACT_STALL   = 3'd1,
        ACT_RET     = 3'd2,
        ACT_RET_ERR = 3'd3,
        ACT_CALL    = 3'd4,
        ACT_JUMP    = 3'd5,
        ACT_BRANCH  = 3'd6,
        ACT_SEQ     = 3'd7
    } seq_act_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control-unit <-> sequencer signal bundle.
//   master : control unit side (drives boot vector and redirect controls)
//   slave  : sequencer side (drives pc, status and RAS flags)
// Optional: PC_ALIGN_CHECK_EN adds the misalign status line.
interface pc_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] load_pc;
    logic              stall;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_target;
    logic              jump;
    logic              call;
    logic [ADDR_W-1:0] jump_target;
    logic              ret;
    logic              halt;
    logic              resume;
    logic [ADDR_W-1:0] pc;
    logic              pc_valid;
    logic              halted;
    logic              ras_empty;
    logic              ras_full;
    logic              ras_err;
`ifdef PC_ALIGN_CHECK_EN
    logic              misalign;
`endif

    modport master (
        output load_pc, stall, branch_taken, branch_target, jump, call,
               jump_target, ret, halt, resume,
        input  pc, pc_valid, halted, ras_empty, ras_full, ras_err
`ifdef PC_ALIGN_CHECK_EN
        , input misalign
`endif
    );

    modport slave (
        input  load_pc, stall, branch_taken, branch_target, jump, call,
               jump_target, ret, halt, resume,
        output pc, pc_valid, halted, ras_empty, ras_full, ras_err
`ifdef PC_ALIGN_CHECK_EN
        , output misalign
`endif
    );

endinterface

// File: rtl/ras_stack.sv
// ras_stack: circular return-address stack.
//   clk, reset (async, active-low), push/push_data, pop
//   top   : most recently pushed surviving entry
//   empty : no entries held; full : RAS_DEPTH entries held
// A push while full overwrites the oldest entry; the count saturates.
module ras_stack #(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_data,
    input  logic              pop,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              full
);
    localparam int PTR_W = $clog2(RAS_DEPTH);

    logic [ADDR_W-1:0] mem [RAS_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;   // next slot to write; top lives one below
    logic [PTR_W:0]    count;

    assign top   = mem[wr_ptr - PTR_W'(1)];
    assign empty = (count == '0);
    assign full  = (count == (PTR_W+1)'(RAS_DEPTH));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
            if (!full)
                count <= count + (PTR_W+1)'(1);
        end else if (pop && !empty) begin
            wr_ptr <= wr_ptr - PTR_W'(1);
            count  <= count - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: FSM-driven program counter with return-address stack.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : pc_sequencer_if.slave (boot vector, redirect controls, pc and status)
// Optional: PC_ALIGN_CHECK_EN forces redirect targets onto INSTR_BYTES
// boundaries and pulses bus.misalign alongside the corrected pc.
//
// state | meaning
// BOOT  | waiting for first edge out of reset, then loads load_pc
// RUN   | one prioritised action per edge, pc_valid=1
// HALT  | pc held, pc_valid=0, waits for resume without halt
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int RAS_DEPTH   = 4,
    parameter int INSTR_BYTES = INSTR_BYTES_DEF
) (
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.slave  bus
);
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(INSTR_BYTES - 1);

    seq_state_t        state;
    seq_act_t          act;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] target_ld;
    logic              pc_valid_q;
    logic              halted_q;
    logic              ras_err_q;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_empty;
    logic              ras_full;
    logic              push;
    logic              pop;

    assign pc_inc = pc_q + ADDR_W'(INSTR_BYTES);

    always_comb begin
        act = ACT_SEQ;
        if (bus.halt)              act = ACT_HALT;
        else if (bus.stall)        act = ACT_STALL;
        else if (bus.ret)          act = ras_empty ? ACT_RET_ERR : ACT_RET;
        else if (bus.call)         act = ACT_CALL;
        else if (bus.jump)         act = ACT_JUMP;
        else if (bus.branch_taken) act = ACT_BRANCH;
    end

    always_comb begin
        case (act)
            ACT_RET:            target = ras_top;
            ACT_CALL, ACT_JUMP: target = bus.jump_target;
            ACT_BRANCH:         target = bus.branch_target;
            default:            target = pc_inc;
        endcase
    end

`ifdef PC_ALIGN_CHECK_EN
    logic is_redirect;
    logic misalign_d;
    logic misalign_q;

    assign is_redirect = (act == ACT_RET) || (act == ACT_CALL) ||
                         (act == ACT_JUMP) || (act == ACT_BRANCH);
    assign misalign_d  = is_redirect && ((target & LOW_MASK) != '0);
    assign target_ld   = is_redirect ? (target & ~LOW_MASK) : target;
    assign bus.misalign = misalign_q;
`else
    assign target_ld = target;
`endif

    assign push = (state == ST_RUN) && (act == ACT_CALL);
    assign pop  = (state == ST_RUN) && (act == ACT_RET);

    ras_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (pc_inc),
        .pop       (pop),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_BOOT;
            pc_q       <= '0;
            pc_valid_q <= 1'b0;
            halted_q   <= 1'b0;
            ras_err_q  <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
`ifdef PC_ALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
            case (state)
                ST_BOOT: begin
                    pc_q       <= bus.load_pc;
                    pc_valid_q <= 1'b1;
                    state      <= ST_RUN;
                end
                ST_RUN: begin
                    case (act)
                        ACT_HALT: begin
                            state      <= ST_HALT;
                            pc_valid_q <= 1'b0;
                            halted_q   <= 1'b1;
                        end
                        ACT_STALL: ;
                        default: begin
                            pc_q <= target_ld;
                            if (act == ACT_RET_ERR)
                                ras_err_q <= 1'b1;
`ifdef PC_ALIGN_CHECK_EN
                            misalign_q <= misalign_d;
`endif
                        end
                    endcase
                end
                ST_HALT: begin
                    if (bus.resume && !bus.halt) begin
                        state      <= ST_RUN;
                        pc_valid_q <= 1'b1;
                        halted_q   <= 1'b0;
                    end
                end
                default: state <= ST_BOOT;
            endcase
        end
    end

    assign bus.pc        = pc_q;
    assign bus.pc_valid  = pc_valid_q;
    assign bus.halted    = halted_q;
    assign bus.ras_empty = ras_empty;
    assign bus.ras_full  = ras_full;
    assign bus.ras_err   = ras_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed-vector bench for pc_sequencer (ADDR_W=32,
// RAS_DEPTH=4, INSTR_BYTES=4). Covers PC_ALIGN_CHECK_EN when defined.
module tb_pc_sequencer;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    pc_sequencer_if #(.ADDR_W(32)) bus ();

    pc_sequencer #(
        .ADDR_W      (32),
        .RAS_DEPTH   (4),
        .INSTR_BYTES (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // advance one edge, then settle before sampling
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_ctl();
        bus.stall        = 1'b0;
        bus.branch_taken = 1'b0;
        bus.jump         = 1'b0;
        bus.call         = 1'b0;
        bus.ret          = 1'b0;
        bus.halt         = 1'b0;
        bus.resume       = 1'b0;
    endtask

    logic [31:0] call_tgt [5];
    logic [31:0] ret_exp  [4];

    initial begin
        n_checks = 0;
        n_pass   = 0;
        call_tgt[0] = 32'h0040_1000; call_tgt[1] = 32'h0040_2000;
        call_tgt[2] = 32'h0040_3000; call_tgt[3] = 32'h0040_4000;
        call_tgt[4] = 32'h0040_5000;
        ret_exp[0] = 32'h0040_4004; ret_exp[1] = 32'h0040_3004;
        ret_exp[2] = 32'h0040_2004; ret_exp[3] = 32'h0040_1004;

        reset             = 1'b0;
        bus.load_pc       = 32'h0040_0020;
        bus.branch_target = '0;
        bus.jump_target   = '0;
        clr_ctl();
        #2;
        check("rst_pc",        bus.pc,        32'h0);
        check("rst_pc_valid",  bus.pc_valid,  32'h0);
        check("rst_halted",    bus.halted,    32'h0);
        check("rst_ras_empty", bus.ras_empty, 32'h1);
        check("rst_ras_full",  bus.ras_full,  32'h0);
        check("rst_ras_err",   bus.ras_err,   32'h0);
        #8 reset = 1'b1;  // t=10, first edge after release at t=15

        // boot with redirects asserted: must be ignored in BOOT
        bus.jump = 1'b1; bus.jump_target = 32'h0000_1234;
        step();
        check("boot_pc",       bus.pc,       32'h0040_0020);
        check("boot_pc_valid", bus.pc_valid, 32'h1);
        bus.jump = 1'b0;
        step(); check("seq_pc1", bus.pc, 32'h0040_0024);
        step(); check("seq_pc2", bus.pc, 32'h0040_0028);

        // call then ret
        bus.call = 1'b1; bus.jump_target = 32'h0040_0100;
        step();
        check("call_pc",    bus.pc,        32'h0040_0100);
        check("call_empty", bus.ras_empty, 32'h0);
        bus.call = 1'b0; bus.ret = 1'b1;
        step();
        check("ret_pc",    bus.pc,        32'h0040_002C);
        check("ret_empty", bus.ras_empty, 32'h1);
        bus.ret = 1'b0;

        // RAS overflow: five calls into a 4-deep stack
        bus.call = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.jump_target = call_tgt[i];
            step();
            check("ovf_call_pc", bus.pc, call_tgt[i]);
            if (i == 3) check("ovf_full4", bus.ras_full, 32'h1);
        end
        check("ovf_full5", bus.ras_full, 32'h1);
        bus.call = 1'b0; bus.ret = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("ovf_ret_pc", bus.pc, ret_exp[i]);
        end
        check("ovf_empty",  bus.ras_empty, 32'h1);
        check("ovf_err_lo", bus.ras_err,   32'h0);
        step();
        check("uflow_pc",  bus.pc,      32'h0040_1008);
        check("uflow_err", bus.ras_err, 32'h1);
        bus.ret = 1'b0;
        step();
        check("uflow_pc2",   bus.pc,      32'h0040_100C);
        check("err_sticky",  bus.ras_err, 32'h1);

        // priority: stall beats branch and jump; then jump beats branch
        bus.stall = 1'b1;
        bus.branch_taken = 1'b1; bus.branch_target = 32'h0040_0200;
        bus.jump = 1'b1;         bus.jump_target   = 32'h0040_0300;
        step();
        check("stall_pc",    bus.pc,       32'h0040_100C);
        check("stall_valid", bus.pc_valid, 32'h1);
        bus.stall = 1'b0;
        step();
        check("jmp_over_br", bus.pc, 32'h0040_0300);
        bus.jump = 1'b0;
        step();
        check("branch_pc", bus.pc, 32'h0040_0200);
        bus.branch_taken = 1'b0;
        // call+ret with empty RAS: ret wins, no push
        bus.call = 1'b1; bus.ret = 1'b1; bus.jump_target = 32'h0040_0800;
        step();
        check("callret_pc",    bus.pc,        32'h0040_0204);
        check("callret_empty", bus.ras_empty, 32'h1);
        clr_ctl();

        // wrap and halt/resume
        bus.jump = 1'b1; bus.jump_target = 32'hFFFF_FFFC;
        step();
        check("pre_wrap", bus.pc, 32'hFFFF_FFFC);
        bus.jump = 1'b0;
        step();
        check("wrap_pc", bus.pc, 32'h0000_0000);
        bus.halt = 1'b1;
        step();
        check("halt_pc",     bus.pc,       32'h0);
        check("halt_valid",  bus.pc_valid, 32'h0);
        check("halt_halted", bus.halted,   32'h1);
        bus.halt = 1'b0;
        step();
        check("halt_hold_pc", bus.pc,     32'h0);
        bus.halt = 1'b1; bus.resume = 1'b1;
        step();
        check("halt_res_stay", bus.halted, 32'h1);
        bus.halt = 1'b0;
        step();
        check("resume_valid",  bus.pc_valid, 32'h1);
        check("resume_halted", bus.halted,   32'h0);
        check("resume_pc",     bus.pc,       32'h0);
        bus.resume = 1'b0;
        step();
        check("post_res_pc", bus.pc, 32'h0000_0004);

        // alignment handling of a misaligned jump target
        bus.jump = 1'b1; bus.jump_target = 32'h0040_0102;
        step();
`ifdef PC_ALIGN_CHECK_EN
        check("align_pc",     bus.pc,       32'h0040_0100);
        check("misalign_hi",  bus.misalign, 32'h1);
        bus.jump = 1'b0;
        step();
        check("misalign_lo",  bus.misalign, 32'h0);
        check("align_seq_pc", bus.pc,       32'h0040_0104);
`else
        check("noalign_pc", bus.pc, 32'h0040_0102);
        bus.jump = 1'b0;
        step();
        check("noalign_seq_pc", bus.pc, 32'h0040_0106);
`endif

        // reset mid-run discards RAS and sticky error
        bus.call = 1'b1;
        bus.jump_target = 32'h0050_0000; step();
        bus.jump_target = 32'h0060_0000; step();
        bus.jump_target = 32'h0070_0000; step();
        check("pre_rst_empty", bus.ras_empty, 32'h0);
        bus.call = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("mid_rst_pc",    bus.pc,        32'h0);
        check("mid_rst_valid", bus.pc_valid,  32'h0);
        check("mid_rst_empty", bus.ras_empty, 32'h1);
        check("mid_rst_err",   bus.ras_err,   32'h0);
        #2 reset = 1'b1;
        step();
        check("reboot_pc", bus.pc, 32'h0040_0020);
        bus.ret = 1'b1;
        step();
        check("reboot_ret_pc",  bus.pc,      32'h0040_0024);
        check("reboot_ret_err", bus.ras_err, 32'h1);
        bus.ret = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
